// File: rtl/wide_serial_adder_pkg.sv
// wsa_pkg: shared definitions for the wide serial adder.
//   state_t   - controller state encoding (IDLE / RUN / DONE)
//   WSA_WIDTH - default operand/result width in bits
//   WSA_CHUNK - default number of bits added per clock
package wsa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WSA_WIDTH = 256;
    localparam int WSA_CHUNK = 32;

endpackage

// File: rtl/wide_serial_adder_chunk_adder.sv
// chunk_adder: combinational CHUNK-bit full adder.
// Ports:
//   a, b  in   CHUNK  addends
//   ci    in   1      carry in
//   s     out  CHUNK  sum bits
//   co    out  1      carry out
module chunk_adder #(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    // One extra bit of headroom captures the carry out of the chunk.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/wide_serial_adder.sv
// wide_serial_adder: multi-cycle WIDTH-bit adder, CHUNK bits per clock,
// least-significant chunk first, carry held in a flop between chunks.
// One operation in flight, valid/ready handshake on both sides.
//
// Optional feature: define WSA_SUB_EN to add the 'sub' input. When sub=1
// at acceptance the block computes a - b (as a + ~b + 1, cin ignored) and
// cout=1 means no borrow.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand request
//   in_ready   out  1      high only in IDLE
//   a, b       in   WIDTH  operands (latched on accept)
//   cin        in   1      carry into bit 0
//   sub        in   1      subtract select (WSA_SUB_EN builds only)
//   out_valid  out  1      high only in DONE
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1
//   busy       out  1      high in RUN or DONE
module wide_serial_adder
    import wsa_pkg::*;
#(
    parameter int WIDTH = WSA_WIDTH,
    parameter int CHUNK = WSA_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef WSA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH)) begin : g_chunk_range_check
            $error("wide_serial_adder: CHUNK must be in 1..WIDTH");
        end
        if ((WIDTH % CHUNK) != 0) begin : g_chunk_div_check
            $error("wide_serial_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx;

    logic             accept;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;

    assign accept = (state == IDLE) && in_valid;

    // Subtraction is folded into the operand latch: invert b and force a
    // carry-in of one, so the datapath itself only ever adds.
`ifdef WSA_SUB_EN
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    // Operands are pure data: captured on accept, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b_in;
        end
    end

    assign chunk_a = a_q[int'(idx) * CHUNK +: CHUNK];
    assign chunk_b = b_q[int'(idx) * CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a  (chunk_a),
        .b  (chunk_b),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            idx       <= '0;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        carry_q  <= c_in;
                        idx      <= '0;
                        sum      <= '0;
                        cout     <= 1'b0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(idx) * CHUNK +: CHUNK] <= chunk_s;
                    carry_q <= chunk_co;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout      <= chunk_co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Result stays put until the consumer takes it; a new
                    // operation is only accepted from the following cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wide_serial_adder.sv
module tb_wide_serial_adder;

    localparam int W = 256;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    wide_serial_adder #(
        .WIDTH (256),
        .CHUNK (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef WSA_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands for one accepting edge, then scramble the inputs and
    // wait (bounded) for out_valid, returning the observed latency.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic sb, output int lat);
        @(negedge clk);
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {8{$urandom()}}; b = {8{$urandom()}}; cin = ~ci; sub = ~sb;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_after"}, W'(out_valid), W'(0));
        check({tag, "_iready_after"}, W'(in_ready), W'(1));
        check({tag, "_busy_after"},   W'(busy),     W'(0));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] top;
        logic [W-1:0] held;
        int lat;

        ones = '1;
        top  = '0;
        top[W-1] = 1'b1;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  W'(in_ready),  W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy",      W'(busy),      W'(0));
        check("rst_sum",       sum,           '0);
        check("rst_cout",      W'(cout),      W'(0));
        rst_n = 1'b1;

        // Idle with in_valid low: nothing accepted
        repeat (3) @(posedge clk); #1;
        check("idle_busy",     W'(busy),     W'(0));
        check("idle_in_ready", W'(in_ready), W'(1));

        // 1: all-ones + 1 wraps to zero with carry out
        run_op(ones, W'(1), 1'b0, 1'b0, lat);
        check("t1_latency", W'(lat),       W'(8));
        check("t1_sum",     sum,           '0);
        check("t1_cout",    W'(cout),      W'(1));
        check("t1_busy",    W'(busy),      W'(1));
        check("t1_iready",  W'(in_ready),  W'(0));
        drain("t1");

        // 2: carry crosses from chunk 0 into chunk 1
        run_op(W'(64'h0000_0000_FFFF_FFFF), W'(1), 1'b0, 1'b0, lat);
        check("t2_latency", W'(lat),  W'(8));
        check("t2_sum",     sum,      W'(64'h1_0000_0000));
        check("t2_cout",    W'(cout), W'(0));
        drain("t2");

        // 3: carry-in alone
        run_op('0, '0, 1'b1, 1'b0, lat);
        check("t3_latency", W'(lat),  W'(8));
        check("t3_sum",     sum,      W'(1));
        check("t3_cout",    W'(cout), W'(0));
        drain("t3");

        // 4: back-pressure in DONE; (2^255+5)+(2^255+3) = 8 carry 1
        run_op(top | W'(5), top | W'(3), 1'b0, 1'b0, lat);
        check("t4_latency", W'(lat),  W'(8));
        check("t4_sum",     sum,      W'(8));
        check("t4_cout",    W'(cout), W'(1));
        held = sum;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t4_hold_sum",    sum,            held);
            check("t4_hold_cout",   W'(cout),       W'(1));
            check("t4_hold_ovalid", W'(out_valid),  W'(1));
            check("t4_hold_iready", W'(in_ready),   W'(0));
        end
        drain("t4");

        // 5: reset during the third RUN cycle aborts the operation
        @(negedge clk);
        a = ones; b = ones; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_ovalid", W'(out_valid), W'(0));
        check("t5_rst_sum",    sum,           '0);
        check("t5_rst_iready", W'(in_ready),  W'(1));
        check("t5_rst_busy",   W'(busy),      W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("t5_post_iready", W'(in_ready),  W'(1));
        check("t5_post_ovalid", W'(out_valid), W'(0));
        check("t5_post_sum",    sum,           '0);
        run_op(W'(3), W'(4), 1'b0, 1'b0, lat);
        check("t5_latency", W'(lat),  W'(8));
        check("t5_sum",     sum,      W'(7));
        check("t5_cout",    W'(cout), W'(0));
        drain("t5");

`ifdef WSA_SUB_EN
        // 6: subtraction, with cin driven high to show it is ignored
        run_op(W'(5), W'(7), 1'b1, 1'b1, lat);
        check("t6a_latency", W'(lat),  W'(8));
        check("t6a_sum",     sum,      ones - W'(1));
        check("t6a_cout",    W'(cout), W'(0));
        drain("t6a");
        run_op(W'(7), W'(5), 1'b1, 1'b1, lat);
        check("t6b_sum",  sum,      W'(2));
        check("t6b_cout", W'(cout), W'(1));
        drain("t6b");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
